ex_muldiv: RTL and testbench

Parametrised, iterative multiply/divide unit for the execute stage, implementing the full RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for any XLEN. It succeeds the fixed-width 32-bit M unit and adds three things that unit lacks:
- a configurable bits-per-cycle radix,
- an early-out path for division corner cases,
- an abort input for pipeline flushes.

It sits beside the ALU in the EX stage. It drives the stage stall directly, and EX selects its result whenever `i_en` is high.

---
 rtl/ex_muldiv.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension multiply/divide unit for the EX stage.
// Shift-add multiply / restoring divide, UNROLL bits per cycle, divide early-out and kill.
//   state | meaning
//   IDLE  | waiting for i_en; operand magnitudes and result sign latched on accept
//   CALC  | iterating, cnt cycles remaining
//   DONE  | result register valid, stall released for one cycle
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_stall
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (!((XLEN == 32 || XLEN == 64) && (UNROLL == 1 || UNROLL == 2 || UNROLL == 4) &&
        (XLEN % UNROLL == 0))) begin : g_bad_param
    $error("ex_muldiv: unsupported XLEN/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd, hi, lo, res;
  logic [XLEN-1:0]   hi_s, lo_s, res_fin;
  logic [XLEN:0]     acc;
  logic              ge;
  logic [2*XLEN-1:0] full;

  logic              in_div, s1_sgn, s2_sgn, s1_neg, s2_neg, neg_in, corner;
  logic [XLEN-1:0]   mag1, mag2, corner_res;

  // Operand decode for the accept cycle
  always_comb begin
    in_div     = i_f3[2];
    s1_sgn     = in_div ? ~i_f3[0] : (i_f3 != 3'b011);
    s2_sgn     = in_div ? ~i_f3[0] : ~i_f3[1];
    s1_neg     = s1_sgn & i_rs1[XLEN-1];
    s2_neg     = s2_sgn & i_rs2[XLEN-1];
    mag1       = s1_neg ? -i_rs1 : i_rs1;
    mag2       = s2_neg ? -i_rs2 : i_rs2;
    neg_in     = (in_div & i_f3[1]) ? s1_neg : (s1_neg ^ s2_neg);
    corner     = 1'b0;
    corner_res = '0;
    if (in_div && i_rs2 == '0) begin
      corner     = 1'b1;
      corner_res = i_f3[1] ? i_rs1 : '1;
    end else if (in_div && !i_f3[0] && i_rs1 == MIN_NEG && i_rs2 == '1) begin
      corner     = 1'b1;
      corner_res = i_f3[1] ? '0 : i_rs1;
    end
  end

  // hi:lo is the running product (multiply) or remainder:quotient (divide)
  always_comb begin
    hi_s = hi;
    lo_s = lo;
    acc  = '0;
    ge   = 1'b0;
    for (int k = 0; k < UNROLL; k++) begin
      if (op[2]) begin
        acc  = {hi_s, lo_s[XLEN-1]};
        ge   = (acc >= {1'b0, opnd});
        lo_s = {lo_s[XLEN-2:0], ge};
        hi_s = ge ? (acc[XLEN-1:0] - opnd) : acc[XLEN-1:0];
      end else begin
        acc  = lo_s[0] ? ({1'b0, hi_s} + {1'b0, opnd}) : {1'b0, hi_s};
        hi_s = acc[XLEN:1];
        lo_s = {acc[0], lo_s[XLEN-1:1]};
      end
    end
    full = neg ? -{hi_s, lo_s} : {hi_s, lo_s};
    if (!op[2]) begin
      res_fin = (op[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end else if (op[1]) begin
      res_fin = neg ? -hi_s : hi_s;
    end else begin
      res_fin = neg ? -lo_s : lo_s;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (i_en) begin
          if (corner) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
            cnt_nxt   = CW'(N);
          end
        end
      end
      CALC: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && state_nxt == DONE) begin
        res <= corner_res;
      end else if (state == CALC && state_nxt == DONE) begin
        res <= res_fin;
      end
    end
  end

  // Datapath needs no reset: it is reloaded on every IDLE cycle
  always_ff @(posedge i_clk) begin
    if (state == IDLE) begin
      op   <= i_f3;
      neg  <= neg_in;
      hi   <= '0;
      opnd <= i_f3[2] ? mag2 : mag1;
      lo   <= i_f3[2] ? mag1 : mag2;
    end else if (state == CALC) begin
      hi <= hi_s;
      lo <= lo_s;
    end
  end

  assign o_res   = res;
  assign o_stall = i_en & ~i_kill & (state != DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: three configurations (32/1, 32/4, 64/2)
// checked against a plain-arithmetic reference model of the M-extension.
module tb_ex_muldiv;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, kill;
  logic [2:0]  en, stall, f3;
  logic [63:0] rs1, rs2;
  logic [31:0] res0, res1;
  logic [63:0] res2;

  int          checks = 0, failures = 0;
  int          sel = 0;
  int          exp_lat = 0;
  int          stall_cnt = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] res_mux, prev;
  logic        stall_mux;

  ex_muldiv #(.XLEN(32), .UNROLL(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_kill(kill), .i_rs1(rs1[31:0]),
    .i_rs2(rs2[31:0]), .i_f3(f3), .o_res(res0), .o_stall(stall[0]));
  ex_muldiv #(.XLEN(32), .UNROLL(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_kill(kill), .i_rs1(rs1[31:0]),
    .i_rs2(rs2[31:0]), .i_f3(f3), .o_res(res1), .o_stall(stall[1]));
  ex_muldiv #(.XLEN(64), .UNROLL(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en[2]), .i_kill(kill), .i_rs1(rs1),
    .i_rs2(rs2), .i_f3(f3), .o_res(res2), .o_stall(stall[2]));

  always_comb begin
    case (sel)
      0:       res_mux = {32'd0, res0};
      1:       res_mux = {32'd0, res1};
      default: res_mux = res2;
    endcase
    stall_mux = stall[sel];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_corner(input int xl, input logic [2:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, minv;
    m    = mask_of(xl);
    a    = a_in & m;
    b    = b_in & m;
    minv = (m >> 1) + 64'd1;
    return op[2] && (b == 64'd0 || (!op[0] && a == minv && b == m));
  endfunction

  // Reference: 128-bit arithmetic on sign/zero-extended operands
  function automatic logic [63:0] ref_op(input int xl, input logic [2:0] op,
                                         input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0]  m, a, b, minv;
    logic [127:0] ua, ub, sa, sb, p;
    m    = mask_of(xl);
    a    = a_in & m;
    b    = b_in & m;
    minv = (m >> 1) + 64'd1;
    ua   = {64'd0, a};
    ub   = {64'd0, b};
    sa   = ((a & minv) != 64'd0) ? ua - (128'd1 << xl) : ua;
    sb   = ((b & minv) != 64'd0) ? ub - (128'd1 << xl) : ub;
    case (op)
      MUL:    p = sa * sb;
      MULH:   p = (sa * sb) >> xl;
      MULHSU: p = (sa * ub) >> xl;
      MULHU:  p = (ua * ub) >> xl;
      default: begin
        if (b == 64'd0) return op[1] ? a : m;
        if (!op[0] && a == minv && b == m) return op[1] ? 64'd0 : a;
        if (!op[0]) p = op[1] ? 128'($signed(sa) % $signed(sb)) : 128'($signed(sa) / $signed(sb));
        else        p = op[1] ? (ua % ub) : (ua / ub);
      end
    endcase
    return p[63:0] & m;
  endfunction

  // Compare process: on each result cycle, stall length and result must match the model
  always @(negedge clk) begin
    if (!rst || kill || !en[sel]) begin
      stall_cnt = 0;
    end else if (stall_mux) begin
      stall_cnt++;
    end else begin
      check("stall_cycles", 64'(stall_cnt), 64'(exp_lat));
      check("result", res_mux, exp_res);
      stall_cnt = 0;
    end
  end

  task automatic start_op(input int s, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input bit use_lit, input logic [63:0] lit);
    int xl, n;
    logic [63:0] mres;
    xl   = (s == 2) ? 64 : 32;
    n    = (s == 1) ? 8 : 32;
    mres = ref_op(xl, op, a, b);
    if (use_lit) check("model_pin", mres, lit);
    sel     = s;
    rs1     = a;
    rs2     = b;
    f3      = op;
    exp_res = mres;
    exp_lat = is_corner(xl, op, a, b) ? 1 : n + 1;
    en[s]   = 1'b1;
  endtask

  task automatic wait_result();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!stall_mux) seen = 1'b1;
    end
    check("result_timeout", 64'(seen), 64'd1);
  endtask

  task automatic issue(input int s, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit use_lit, input logic [63:0] lit,
                       input bit hold);
    @(posedge clk); #1;
    start_op(s, op, a, b, use_lit, lit);
    wait_result();
    if (!hold) begin
      @(posedge clk); #1;
      en[s] = 1'b0;
    end
  endtask

  logic [63:0] va [5] = '{64'h0000_0000_FFFF_FFF9, 64'h1234_5678_9ABC_DEF0,
                          64'h8000_0000_8000_0000, 64'hFFFF_FFFF_7FFF_FFFF,
                          64'h8000_0000_0000_0000};
  logic [63:0] vb [5] = '{64'd3, 64'hFFFF_FFFF_FEDC_BA98, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF};

  initial begin
    rst = 1'b0; kill = 1'b0; en = '0; rs1 = '0; rs2 = '0; f3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res0", 64'(res0), 64'd0);
    check("rst_res1", 64'(res1), 64'd0);
    check("rst_res2", res2, 64'd0);
    check("rst_stall_idle", 64'(stall), 64'd0);
    en[0] = 1'b1;
    #1;
    check("rst_stall_en", 64'(stall[0]), 64'd1);
    en  = '0;
    rst = 1'b1;

    issue(0, MUL,    64'd7,        64'hFFFF_FFFD, 1, 64'hFFFF_FFEB, 0);
    issue(0, MULH,   64'h8000_0000, 64'h8000_0000, 1, 64'h4000_0000, 0);
    issue(0, MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFE, 0);
    issue(0, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF, 0);
    issue(0, DIV,    64'hFFFF_FFF9, 64'd2,        1, 64'hFFFF_FFFD, 0);
    issue(0, REM,    64'hFFFF_FFF9, 64'd2,        1, 64'hFFFF_FFFF, 0);
    issue(0, DIVU,   64'd100,      64'd7,        1, 64'd14,        0);
    issue(0, REMU,   64'd100,      64'd7,        1, 64'd2,         0);
    issue(0, DIVU,   64'd5,        64'd0,        1, 64'hFFFF_FFFF, 0);
    issue(0, REM,    64'd5,        64'd0,        1, 64'd5,         0);
    issue(0, DIV,    64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h8000_0000, 0);
    issue(0, REM,    64'h8000_0000, 64'hFFFF_FFFF, 1, 64'd0,         0);

    // Kill on CALC cycle 10, then MUL issued the following cycle
    @(posedge clk); #1;
    start_op(0, DIV, 64'd100, 64'd7, 0, 64'd0);
    prev = res_mux;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(negedge clk);
    check("kill_stall", 64'(stall_mux), 64'd0);
    check("kill_res_hold", res_mux, prev);
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_no_update", res_mux, prev);
    start_op(0, MUL, 64'd3, 64'd4, 1, 64'd12);
    wait_result();
    @(posedge clk); #1;
    en[0] = 1'b0;

    // Reset pulled mid-operation
    @(posedge clk); #1;
    start_op(0, DIVU, 64'd1000, 64'd3, 1, 64'd333);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_res", res_mux, 64'd0);
    check("midrst_stall", 64'(stall_mux), 64'd1);
    en[0] = 1'b0;
    rst   = 1'b1;
    issue(0, REMU, 64'd1000, 64'd3, 1, 64'd1, 0);

    // Back-to-back with i_en held high
    issue(0, MUL,  64'h0001_0000, 64'h0000_0300, 1, 64'h0300_0000, 1);
    issue(0, DIVU, 64'd1000,     64'd7,        1, 64'd142,       0);
    issue(1, MUL,  64'hFFFF_FFFF, 64'd5,        1, 64'hFFFF_FFFB, 1);
    issue(1, DIVU, 64'd100,      64'd7,        1, 64'd14,        0);
    issue(2, MULHU, 64'h8000_0000_0000_0000, 64'd4, 1, 64'd2, 1);
    issue(2, DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1, 64'h0FFF_FFFF_FFFF_FFFF, 0);
    issue(2, DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
          64'h8000_0000_0000_0000, 0);

    // Mixed-sign operand table across every op and configuration
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 5; p++) begin
        for (int k = 0; k < 8; k++) begin
          issue(s, 3'(k), va[p], vb[p], 0, 64'd0, 0);
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
